// File: rtl/lenet_pkg.sv
// Shared tensor geometry helpers and FSM encoding for the flattened-tensor
// activation interface.
package lenet_pkg;

   localparam int DEF_BITWIDTH    = 16;
   localparam int DEF_DATAWIDTH   = 7;
   localparam int DEF_DATAHEIGHT  = 7;
   localparam int DEF_DATACHANNEL = 4;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_SEND = 1'b1;

   typedef enum logic {
      S_IDLE = ST_IDLE,
      S_SEND = ST_SEND
   } state_t;

   // Index width that never collapses to zero for single-entry dimensions.
   function automatic int idx_w(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int elem_off(input int c, input int r, input int k,
                                   input int h, input int w, input int bw);
      return ((c * h + r) * w + k) * bw;
   endfunction

endpackage

// File: rtl/tensor_index_counter.sv
// Nested channel/row/column walker with clear, advance and first/last flags;
// wraps back to (0,0,0) after the last element.
module tensor_index_counter
   import lenet_pkg::*;
#(
   parameter int C = DEF_DATACHANNEL,
   parameter int H = DEF_DATAHEIGHT,
   parameter int W = DEF_DATAWIDTH
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                adv,
   output logic [idx_w(C)-1:0] c,
   output logic [idx_w(H)-1:0] r,
   output logic [idx_w(W)-1:0] k,
   output logic                first,
   output logic                last
);

   localparam int CW = idx_w(C);
   localparam int RW = idx_w(H);
   localparam int KW = idx_w(W);
   localparam logic [CW-1:0] C_MAX = CW'(C - 1);
   localparam logic [RW-1:0] R_MAX = RW'(H - 1);
   localparam logic [KW-1:0] K_MAX = KW'(W - 1);

   logic k_wrap;
   logic r_wrap;
   logic c_wrap;

   assign k_wrap = (k == K_MAX);
   assign r_wrap = (r == R_MAX);
   assign c_wrap = (c == C_MAX);
   assign first  = (c == '0) && (r == '0) && (k == '0);
   assign last   = c_wrap && r_wrap && k_wrap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c <= '0;
         r <= '0;
         k <= '0;
      end else if (clr) begin
         c <= '0;
         r <= '0;
         k <= '0;
      end else if (adv) begin
         if (k_wrap) begin
            k <= '0;
            if (r_wrap) begin
               r <= '0;
               c <= c_wrap ? '0 : c + 1'b1;
            end else begin
               r <= r + 1'b1;
            end
         end else begin
            k <= k + 1'b1;
         end
      end
   end

endmodule

// File: rtl/tensor_stream_tx.sv
// Registers one flattened activation tensor on a load handshake and streams it
// out element by element with coordinate and first/last tags.
module tensor_stream_tx
   import lenet_pkg::*;
#(
   parameter int BITWIDTH    = DEF_BITWIDTH,
   parameter int DATAWIDTH   = DEF_DATAWIDTH,
   parameter int DATAHEIGHT  = DEF_DATAHEIGHT,
   parameter int DATACHANNEL = DEF_DATACHANNEL
) (
   input  logic                                                clk,
   input  logic                                                rst_n,
   input  logic                                                load_valid,
   output logic                                                load_ready,
   input  logic [BITWIDTH*DATAHEIGHT*DATAWIDTH*DATACHANNEL-1:0] data,
   output logic                                                out_valid,
   input  logic                                                out_ready,
   output logic [BITWIDTH-1:0]                                 out_data,
   output logic [idx_w(DATACHANNEL)-1:0]                       out_chan,
   output logic [idx_w(DATAHEIGHT)-1:0]                        out_row,
   output logic [idx_w(DATAWIDTH)-1:0]                         out_col,
   output logic                                                out_first,
   output logic                                                out_last
);

   localparam int N  = DATACHANNEL * DATAHEIGHT * DATAWIDTH;
   localparam int EW = idx_w(N);

   state_t                     state;
   logic [BITWIDTH-1:0]        tbuf [N];
   logic [idx_w(DATACHANNEL)-1:0] cnt_c;
   logic [idx_w(DATAHEIGHT)-1:0]  cnt_r;
   logic [idx_w(DATAWIDTH)-1:0]   cnt_k;
   logic                       cnt_first;
   logic                       cnt_last;
   logic                       accept;
   logic                       xfer;
   logic [EW-1:0]              elem_idx;

   assign accept = (state == S_IDLE) && load_valid;
   assign xfer   = (state == S_SEND) && out_ready;

   tensor_index_counter #(
      .C (DATACHANNEL),
      .H (DATAHEIGHT),
      .W (DATAWIDTH)
   ) u_idx (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .adv   (xfer),
      .c     (cnt_c),
      .r     (cnt_r),
      .k     (cnt_k),
      .first (cnt_first),
      .last  (cnt_last)
   );

   // Load and stream never overlap: the buffer is only written from IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         for (int e = 0; e < N; e++) tbuf[e] <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (load_valid) begin
                  for (int e = 0; e < N; e++) tbuf[e] <= data[e*BITWIDTH +: BITWIDTH];
                  state <= S_SEND;
               end
            end
            S_SEND: begin
               if (out_ready && cnt_last) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign load_ready = (state == S_IDLE);
   assign out_valid  = (state == S_SEND);

   assign elem_idx  = EW'(elem_off(int'(cnt_c), int'(cnt_r), int'(cnt_k),
                                   DATAHEIGHT, DATAWIDTH, 1));
   assign out_data  = out_valid ? tbuf[elem_idx] : '0;
   assign out_chan  = cnt_c;
   assign out_row   = cnt_r;
   assign out_col   = cnt_k;
   assign out_first = out_valid && cnt_first;
   assign out_last  = out_valid && cnt_last;

endmodule

// File: tb/tb_tensor_stream_tx.sv
// Scoreboard bench for tensor_stream_tx at three geometries: 4x7x7, 2x2x3, 1x1x1.
module tb_tensor_stream_tx;

   localparam int BW = 16;
   localparam int C0 = 4, H0 = 7, W0 = 7, N0 = 196;
   localparam int C1 = 2, H1 = 2, W1 = 3, N1 = 12;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic            lv0 = 0, lr0, ov0, or0 = 0, of0, ol0;
   logic [N0*BW-1:0] d0 = '0;
   logic [15:0]     od0;
   logic [1:0]      oc0;
   logic [2:0]      orw0, ok0;

   logic            lv1 = 0, lr1, ov1, or1 = 0, of1, ol1;
   logic [N1*BW-1:0] d1 = '0;
   logic [15:0]     od1;
   logic [0:0]      oc1, orw1;
   logic [1:0]      ok1;

   logic            lv2 = 0, lr2, ov2, or2 = 0, of2, ol2;
   logic [BW-1:0]   d2 = '0;
   logic [15:0]     od2;
   logic [0:0]      oc2, orw2, ok2;

   tensor_stream_tx u0 (
      .clk(clk), .rst_n(rst_n), .load_valid(lv0), .load_ready(lr0), .data(d0),
      .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_chan(oc0),
      .out_row(orw0), .out_col(ok0), .out_first(of0), .out_last(ol0));

   tensor_stream_tx #(.BITWIDTH(16), .DATAWIDTH(3), .DATAHEIGHT(2), .DATACHANNEL(2)) u1 (
      .clk(clk), .rst_n(rst_n), .load_valid(lv1), .load_ready(lr1), .data(d1),
      .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_chan(oc1),
      .out_row(orw1), .out_col(ok1), .out_first(of1), .out_last(ol1));

   tensor_stream_tx #(.BITWIDTH(16), .DATAWIDTH(1), .DATAHEIGHT(1), .DATACHANNEL(1)) u2 (
      .clk(clk), .rst_n(rst_n), .load_valid(lv2), .load_ready(lr2), .data(d2),
      .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_chan(oc2),
      .out_row(orw2), .out_col(ok2), .out_first(of2), .out_last(ol2));

   typedef struct {
      logic [15:0] d;
      int          c;
      int          r;
      int          k;
      bit          f;
      bit          l;
   } exp_t;

   typedef struct {
      int         base;
      int         stride;
      logic [3:0] pat;
      int         exp_x;
   } vec_t;

   exp_t q0[$], q1[$], q2[$];
   int nvec = 0, nmiss = 0;
   int xc0 = 0, xc1 = 0, xc2 = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmiss++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] pk(input logic [15:0] d, input int c, input int r,
                                      input int k, input bit f, input bit l);
      return {16'h0, d, 8'(c), 8'(r), 8'(k), 6'h0, f, l};
   endfunction

   function automatic logic [15:0] ev(input int base, input int stride, input int e);
      return 16'(base + stride * e);
   endfunction

   // Output monitors: every valid cycle must match the scoreboard head, so a
   // stalled element is re-checked against the same entry until it is accepted.
   always @(negedge clk) begin
      if (rst_n && ov0) begin
         if (q0.size() == 0) chk("u0_unexpected_valid", 1, 0);
         else begin
            chk("u0_elem", pk(od0, int'(oc0), int'(orw0), int'(ok0), of0, ol0),
                pk(q0[0].d, q0[0].c, q0[0].r, q0[0].k, q0[0].f, q0[0].l));
            if (or0) begin void'(q0.pop_front()); xc0++; end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && ov1) begin
         if (q1.size() == 0) chk("u1_unexpected_valid", 1, 0);
         else begin
            chk("u1_elem", pk(od1, int'(oc1), int'(orw1), int'(ok1), of1, ol1),
                pk(q1[0].d, q1[0].c, q1[0].r, q1[0].k, q1[0].f, q1[0].l));
            if (or1) begin void'(q1.pop_front()); xc1++; end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && ov2) begin
         if (q2.size() == 0) chk("u2_unexpected_valid", 1, 0);
         else begin
            chk("u2_elem", pk(od2, int'(oc2), int'(orw2), int'(ok2), of2, ol2),
                pk(q2[0].d, q2[0].c, q2[0].r, q2[0].k, q2[0].f, q2[0].l));
            if (or2) begin void'(q2.pop_front()); xc2++; end
         end
      end
   end

   task automatic push_exp(input int which, input int base, input int stride);
      int cc, hh, ww, n, e;
      exp_t x;
      cc = (which == 0) ? C0 : (which == 1) ? C1 : 1;
      hh = (which == 0) ? H0 : (which == 1) ? H1 : 1;
      ww = (which == 0) ? W0 : (which == 1) ? W1 : 1;
      n  = cc * hh * ww;
      for (int c = 0; c < cc; c++)
         for (int r = 0; r < hh; r++)
            for (int k = 0; k < ww; k++) begin
               e   = (c * hh + r) * ww + k;
               x.d = ev(base, stride, e);
               x.c = c; x.r = r; x.k = k;
               x.f = (e == 0);
               x.l = (e == n - 1);
               case (which)
                  0: q0.push_back(x);
                  1: q1.push_back(x);
                  default: q2.push_back(x);
               endcase
            end
   endtask

   function automatic int qsize(input int which);
      case (which)
         0: return q0.size();
         1: return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic logic cur_lr(input int which);
      case (which)
         0: return lr0;
         1: return lr1;
         default: return lr2;
      endcase
   endfunction

   task automatic set_lv(input int which, input logic v);
      case (which)
         0: lv0 = v;
         1: lv1 = v;
         default: lv2 = v;
      endcase
   endtask

   // Drives a tensor and waits for acceptance; returns at accept edge + 1.
   // waited = number of falling edges observed until load_ready was seen high.
   task automatic load(input int which, input int base, input int stride,
                       input bit hold, output int waited);
      bit ok;
      case (which)
         0: for (int e = 0; e < N0; e++) d0[e*BW +: BW] = ev(base, stride, e);
         1: for (int e = 0; e < N1; e++) d1[e*BW +: BW] = ev(base, stride, e);
         default: d2 = ev(base, stride, 0);
      endcase
      push_exp(which, base, stride);
      set_lv(which, 1'b1);
      ok = 0;
      waited = 0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge clk);
         waited++;
         if (cur_lr(which)) ok = 1;
      end
      if (!ok) chk("load_accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      if (!hold) set_lv(which, 1'b0);
   endtask

   task automatic drain(input int which);
      bit ok;
      ok = 0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(posedge clk);
         if (qsize(which) == 0) ok = 1;
      end
      #1;
      if (!ok) chk("drain_timeout", qsize(which), 0);
   endtask

   vec_t tv[4];

   initial begin
      int w, xs;
      bit acc, ok;

      tv[0] = '{base: 0,     stride: 1,    pat: 4'b1001, exp_x: 12};
      tv[1] = '{base: 200,   stride: 17,   pat: 4'b1111, exp_x: 12};
      tv[2] = '{base: 65520, stride: -1,   pat: 4'b0101, exp_x: 12};
      tv[3] = '{base: 3,     stride: 1000, pat: 4'b0011, exp_x: 12};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("u0_reset_state", {ov0, lr0, od0, oc0, orw0, ok0, of0, ol0}, {1'b0, 1'b1, 26'h0});
      chk("u1_reset_state", {ov1, lr1, od1, oc1, orw1, ok1, of1, ol1}, {1'b0, 1'b1, 22'h0});
      chk("u2_reset_state", {ov2, lr2, od2, oc2, orw2, ok2, of2, ol2}, {1'b0, 1'b1, 21'h0});
      @(posedge clk);
      #1;

      // Full default-geometry stream with value = element index.
      or0 = 1;
      xs = xc0;
      load(0, 0, 1, 0, w);
      for (int i = 1; i <= N0; i++) begin
         @(negedge clk);
         chk("u0_streaming_flags", {ov0, lr0}, 2'b10);
      end
      @(negedge clk);
      chk("u0_ready_after_last", {ov0, lr0}, 2'b01);
      chk("u0_stream_count", xc0 - xs, N0);
      chk("u0_queue_empty", q0.size(), 0);
      @(posedge clk);
      #1;

      // Small geometry, table of ready patterns.
      for (int v = 0; v < 4; v++) begin
         xs = xc1;
         for (int e = 0; e < N1; e++) d1[e*BW +: BW] = ev(tv[v].base, tv[v].stride, e);
         push_exp(1, tv[v].base, tv[v].stride);
         lv1 = 1;
         acc = 0;
         ok = 0;
         for (int cyc = 0; cyc < 200 && !ok; cyc++) begin
            or1 = tv[v].pat[cyc % 4];
            @(negedge clk);
            if (lv1 && lr1) acc = 1;
            @(posedge clk);
            #1;
            if (acc) lv1 = 0;
            if (acc && q1.size() == 0) ok = 1;
         end
         chk("tbl_xfer_count", xc1 - xs, tv[v].exp_x);
         @(negedge clk);
         chk("tbl_idle_after", {ov1, lr1}, 2'b01);
         @(posedge clk);
         #1;
      end

      // load_valid held with another tensor during SEND must be ignored.
      or1 = 1;
      load(1, 40, 3, 0, w);
      for (int e = 0; e < N1; e++) d1[e*BW +: BW] = ev(9999, 1, e);
      lv1 = 1;
      for (int i = 1; i <= 11; i++) begin
         @(negedge clk);
         chk("u1_ignore_load", lr1, 1'b0);
      end
      @(posedge clk);
      #1 lv1 = 0;
      drain(1);
      repeat (3) begin
         @(negedge clk);
         chk("u1_no_second_tensor", {ov1, lr1}, 2'b01);
      end
      @(posedge clk);
      #1;

      // Reset during a default stream, then a fresh tensor.
      or0 = 1;
      xs = xc0;
      load(0, 100, 3, 0, w);
      ok = 0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(posedge clk);
         if (xc0 - xs >= 50) ok = 1;
      end
      if (!ok) chk("u0_reach_50_timeout", 0, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("u0_async_abort", {ov0, lr0, od0, oc0, orw0, ok0, of0, ol0}, {1'b0, 1'b1, 26'h0});
      q0.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("u0_after_release", {ov0, lr0}, 2'b01);
      @(posedge clk);
      #1;
      xs = xc0;
      load(0, 7, 5, 0, w);
      @(negedge clk);
      chk("u0_restart_first", {ov0, of0, oc0, orw0, ok0}, {1'b1, 1'b1, 8'h0});
      drain(0);
      chk("u0_restart_count", xc0 - xs, N0);

      // Single-element tensor with an initial stall.
      or2 = 0;
      xs = xc2;
      load(2, 32'h8001, 0, 0, w);
      repeat (3) begin
         @(negedge clk);
         chk("u2_stall_first_last", {ov2, of2, ol2, od2}, {3'b111, 16'h8001});
      end
      @(posedge clk);
      #1 or2 = 1;
      drain(2);
      chk("u2_count", xc2 - xs, 1);
      @(negedge clk);
      chk("u2_idle_after", {ov2, lr2}, 2'b01);
      @(posedge clk);
      #1;

      // Back-to-back tensors with load_valid held high throughout.
      or0 = 1;
      xs = xc0;
      load(0, 1000, 7, 1, w);
      load(0, 5000, -3, 0, w);
      chk("u0_b2b_accept_gap", w, N0 + 1);
      @(negedge clk);
      chk("u0_b_first_latency", {ov0, of0}, 2'b11);
      drain(0);
      chk("u0_b2b_count", xc0 - xs, 2 * N0);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/tensor_stream_tx.md
Name: tensor_stream_tx

Overview:
- Reader/transmitter side of the flattened-tensor activation interface.
- Accepts one complete flattened activation tensor (BITWIDTH*DATAHEIGHT*DATAWIDTH*DATACHANNEL bits) on a load handshake and registers it.
- Streams the tensor out one element per transfer on a valid/ready stream, with first/last and coordinate tags.
- Sits between the parallel activation stage and the serial consumers (next-layer MAC feeder, output buffer).

Parameters:
- BITWIDTH, 16, bits per element
- DATAWIDTH, 7, columns per channel (>=1)
- DATAHEIGHT, 7, rows per channel (>=1)
- DATACHANNEL, 4, channels (>=1)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- load_valid  input  1  flat tensor on data is valid
- load_ready  output  1  block can accept a tensor
- data  input  BITWIDTH*DATAHEIGHT*DATAWIDTH*DATACHANNEL  flat tensor; element e occupies [e*BITWIDTH +: BITWIDTH], e=(c*DATAHEIGHT+r)*DATAWIDTH+k
- out_valid  output  1  out_* fields hold a valid element
- out_ready  input  1  consumer accepts the element
- out_data  output  BITWIDTH  element value
- out_chan  output  max(1,$clog2(DATACHANNEL))  channel index c
- out_row  output  max(1,$clog2(DATAHEIGHT))  row index r
- out_col  output  max(1,$clog2(DATAWIDTH))  column index k
- out_first  output  1  element (0,0,0)
- out_last  output  1  element (C-1,H-1,W-1)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- FSM has two states, IDLE and SEND.
- Reset (async assert, released synchronously by the system) puts the block in IDLE. The buffer and counters are cleared to 0, out_valid=0 and load_ready=1 (after reset). All out_* fields read 0.
- IDLE:
  - load_ready=1, out_valid=0.
  - On load_valid&&load_ready: capture data into the tensor buffer, clear c/r/k to 0, go to SEND.
- SEND:
  - load_ready=0 and out_valid=1. load_valid is ignored.
  - out_data is the buffer element at the current (c,r,k); the coordinate outputs equal the counters.
  - out_first=(c==0&&r==0&&k==0); out_last=(c==C-1&&r==H-1&&k==W-1).
- Transfer occurs on out_valid&&out_ready. Advance order:
  - k increments.
  - When k==W-1, k wraps to 0 and r increments.
  - When r==H-1 as well, r wraps to 0 and c increments.
  - A transfer with out_last=1 returns the FSM to IDLE. Counters wrap to 0.
- Stall: while out_valid=1 and out_ready=0, every out_* field stays stable. The buffer is never modified in SEND.
- Latency and throughput:
  - First element is valid the cycle after load acceptance.
  - With out_ready held at 1, N=C*H*W elements go out on N consecutive cycles.
  - load_ready rises the cycle after the last transfer, so one tensor takes N+1 cycles minimum. There is no overlap of load and stream; this is deliberate.
- N=1 (all parameters 1): the single element has out_first=out_last=1.
- Reset mid-stream: the stream aborts immediately and out_valid drops asynchronously. No partial-tensor state survives reset.
- out_valid does not depend combinationally on out_ready. load_ready depends only on state.
- Data is passed through unmodified: no sign handling and no arithmetic on element values.

Decomposition:
- Shared package (lenet_pkg):
  - Tensor dimension defaults.
  - An index-width function idx_w(n)=max(1,$clog2(n)).
  - The flat element-offset function elem_off(c,r,k,H,W,BW).
  - State encoding localparams ST_IDLE=0, ST_SEND=1.
- One sub-module, tensor_index_counter: nested c/r/k counter with clear, advance, first/last flags and wrap.
- The top level holds the FSM, the buffer and the output mux.

Test Plan:
- Default params, tensor with element e value=e (0..195), out_ready=1 → 196 consecutive transfers with out_data=0..195 in order. out_first on element 0 with (0,0,0); out_last on element 195 with (3,6,6). load_ready=1 one cycle after the last transfer.
- C=2,H=2,W=3, out_ready toggling 1,0,0,1 pattern → all out_* fields stable during stalls. Order is (0,0,0),(0,0,1),(0,0,2),(0,1,0)…(1,1,2). Exactly 12 transfers.
- Load accepted, then load_valid held high with a different tensor during SEND → load_ready=0 throughout. The streamed values are from the first tensor only.
- rst_n pulsed low at transfer 50 of a default stream → out_valid=0 asynchronously and load_ready=1 after release. A new tensor streams from (0,0,0) with correct values.
- C=H=W=1, element 0x8001 → single transfer with out_data=0x8001 and out_first=out_last=1, then IDLE.
- Back-to-back tensors A then B with load_valid held high → B is accepted in the cycle load_ready returns to 1. B's first element follows 1 cycle later; no A/B element mixing.
